// File: rtl/jtag_host_driver.sv
// JTAG host-side sequencer: turns TAP reset / IR scan / DR scan / idle commands
// into TCK/TMS/TDI waveforms and collects the TDO bits shifted out of the TAP.
// Every command starts and ends in Run-Test/Idle.
module jtag_host_driver #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int unsigned CntW = 9;
  localparam int unsigned LenW = 7;
  typedef logic [LenW-1:0] len_t;

  localparam logic [CntW-1:0] HalfEnd = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] FullEnd = CntW'(2 * CLK_DIV - 1);

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpIr    = 2'b01;
  localparam logic [1:0] OpDr    = 2'b10;

  typedef enum logic [1:0] {StInit, StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  len_t               len_q, len_d;
  len_t               bit_q, bit_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  len_t               acc_len;

  function automatic len_t clamp_len(input logic [5:0] len);
    len_t l;
    l = len_t'(len);
    if (l == '0) return len_t'(1);
    if (l > len_t'(MAX_LEN)) return len_t'(MAX_LEN);
    return l;
  endfunction

  // Number of TCK bits the command occupies.
  function automatic len_t total_bits(input logic [1:0] op, input len_t len);
    case (op)
      OpReset: return len_t'(6);
      OpIr:    return len + len_t'(6);
      OpDr:    return len + len_t'(5);
      default: return len;
    endcase
  endfunction

  function automatic logic is_shift(input logic [1:0] op, input len_t len, input len_t k);
    case (op)
      OpIr:    return (k >= len_t'(4)) && (k < len + len_t'(4));
      OpDr:    return (k >= len_t'(3)) && (k < len + len_t'(3));
      default: return 1'b0;
    endcase
  endfunction

  function automatic len_t shift_idx(input logic [1:0] op, input len_t k);
    return (op == OpIr) ? k - len_t'(4) : k - len_t'(3);
  endfunction

  // TMS walks Idle -> Shift-IR/DR -> Exit1 -> Update -> Idle around the shift bits.
  function automatic logic bit_tms(input logic [1:0] op, input len_t len, input len_t k);
    if (is_shift(op, len, k)) return shift_idx(op, k) == len - len_t'(1);
    case (op)
      OpReset: return k < len_t'(5);
      OpIr:    return (k < len_t'(2)) || (k == len + len_t'(4));
      OpDr:    return (k == len_t'(0)) || (k == len + len_t'(3));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pick_bit(input logic [MAX_LEN-1:0] d, input len_t idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (idx == len_t'(i)) b = d[i];
    end
    return b;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      op_q    <= OpReset;
      len_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // Next state: accept, step through TCK bits, sample TDO on the rising half, finish.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    acc_len = clamp_len(cmd_len);
    case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        if (cmd_valid) begin
          state_d = StRun;
          op_d    = cmd_op;
          len_d   = acc_len;
          data_d  = cmd_data;
          bit_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          tck_d   = 1'b0;
          // Bit 0 is never a shift bit, so tdi starts low.
          tms_d   = bit_tms(cmd_op, acc_len, '0);
          tdi_d   = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == HalfEnd) begin
          tck_d = 1'b1;
          if (is_shift(op_q, len_q, bit_q)) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (shift_idx(op_q, bit_q) == len_t'(i)) cap_d[i] = tdo;
            end
          end
        end
        if (cnt_q == FullEnd) begin
          cnt_d = '0;
          bit_d = bit_q + len_t'(1);
          tck_d = 1'b0;
          if (bit_d == total_bits(op_q, len_q)) begin
            state_d = StDone;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            if (op_q == OpIr || op_q == OpDr) rsp_d = cap_q;
          end else begin
            tms_d = bit_tms(op_q, len_q, bit_d);
            tdi_d = is_shift(op_q, len_q, bit_d) ?
                    pick_bit(data_q, shift_idx(op_q, bit_d)) : 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q == StRun);
    rsp_valid = (state_q == StDone) && (op_q == OpIr || op_q == OpDr);
    rsp_data  = rsp_q;
    tck       = tck_q;
    tms       = tms_q;
    tdi       = tdi_q;
  end

endmodule

// File: tb/tb_jtag_host_driver.sv
module tb_jtag_host_driver;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  int tdo_mode;  // 0: tied low, 1: tied high, 2: looped back from tdi
  int passed = 0;
  int total  = 0;
  logic [MAX_LEN-1:0] exp_rsp;
  bit exp_tms_q[$];
  bit exp_tdi_q[$];

  assign tdo = (tdo_mode == 2) ? tdi : (tdo_mode == 1);

  always #5 clk = ~clk;

  jtag_host_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_wait"}, cmd_ready, 1'b1);
  endtask

  // Reference: expected TMS/TDI per TCK rising edge and response, from the sequence rules.
  task automatic build_model(input logic [1:0] op, input logic [5:0] len,
                             input logic [31:0] data, input int mode, output int l_eff);
    l_eff = (len == 0) ? 1 : (int'(len) > MAX_LEN ? MAX_LEN : int'(len));
    exp_tms_q.delete();
    exp_tdi_q.delete();
    case (op)
      2'd0: begin
        for (int i = 0; i < 5; i++) exp_tms_q.push_back(1'b1);
        exp_tms_q.push_back(1'b0);
        for (int i = 0; i < 6; i++) exp_tdi_q.push_back(1'b0);
      end
      2'd1, 2'd2: begin
        if (op == 2'd1) begin
          exp_tms_q.push_back(1'b1);
          exp_tms_q.push_back(1'b1);
          exp_tms_q.push_back(1'b0);
          exp_tms_q.push_back(1'b0);
        end else begin
          exp_tms_q.push_back(1'b1);
          exp_tms_q.push_back(1'b0);
          exp_tms_q.push_back(1'b0);
        end
        while (exp_tdi_q.size() < exp_tms_q.size()) exp_tdi_q.push_back(1'b0);
        for (int i = 0; i < l_eff; i++) begin
          exp_tms_q.push_back(i == l_eff - 1);
          exp_tdi_q.push_back(data[i]);
        end
        exp_tms_q.push_back(1'b1);
        exp_tms_q.push_back(1'b0);
        exp_tdi_q.push_back(1'b0);
        exp_tdi_q.push_back(1'b0);
      end
      default: begin
        for (int i = 0; i < l_eff; i++) begin
          exp_tms_q.push_back(1'b0);
          exp_tdi_q.push_back(1'b0);
        end
      end
    endcase
    if (op == 2'd1 || op == 2'd2) begin
      logic [63:0] mask;
      mask = (64'd1 << l_eff) - 64'd1;
      case (mode)
        0:       exp_rsp = '0;
        1:       exp_rsp = mask[31:0];
        default: exp_rsp = data & mask[31:0];
      endcase
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input int mode, input bit poke);
    int l_eff, t_bits, e_cyc, busy_cnt, rv_cnt, rv_cyc, ready_cyc, n_obs;
    logic prev_tck;
    logic [127:0] obs_tms, obs_tdi, exp_tms, exp_tdi;
    build_model(op, len, data, mode, l_eff);
    t_bits = exp_tms_q.size();
    e_cyc = t_bits * 2 * CLK_DIV;
    exp_tms = '0;
    exp_tdi = '0;
    for (int i = 0; i < t_bits; i++) begin
      exp_tms[i] = exp_tms_q[i];
      exp_tdi[i] = exp_tdi_q[i];
    end
    wait_ready(tag);
    tdo_mode  = mode;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check({tag, "_busy_at_accept"}, busy, 1'b1);
    check({tag, "_ready_at_accept"}, cmd_ready, 1'b0);
    prev_tck = tck;
    busy_cnt = busy ? 1 : 0;
    rv_cnt = 0;
    rv_cyc = -1;
    ready_cyc = -1;
    n_obs = 0;
    obs_tms = '0;
    obs_tdi = '0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(posedge clk);
      #1;
      if (poke && cyc == 7) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_len   = 6'($urandom_range(0, 63));
        cmd_data  = $urandom;
      end
      if (poke && cyc == 8) cmd_valid = 1'b0;
      if (tck && !prev_tck) begin
        if (n_obs < 128) begin
          obs_tms[n_obs] = tms;
          obs_tdi[n_obs] = tdi;
        end
        n_obs++;
      end
      prev_tck = tck;
      if (busy) busy_cnt++;
      if (rsp_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) rv_cyc = cyc;
      end
      if (cmd_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    check({tag, "_tck_pulses"}, n_obs, t_bits);
    check({tag, "_tms_seq"}, obs_tms, exp_tms);
    check({tag, "_tdi_seq"}, obs_tdi, exp_tdi);
    check({tag, "_busy_cycles"}, busy_cnt, e_cyc);
    check({tag, "_ready_return"}, ready_cyc, e_cyc + 1);
    check({tag, "_rsp_valid_count"}, rv_cnt, (op == 2'd1 || op == 2'd2) ? 1 : 0);
    if (op == 2'd1 || op == 2'd2) check({tag, "_rsp_valid_cycle"}, rv_cyc, e_cyc);
    check({tag, "_rsp_data"}, rsp_data, exp_rsp);
  endtask

  initial begin
    int rv_cnt;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    tdo_mode  = 0;
    exp_rsp   = '0;

    // Reset values and first ready edge.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {cmd_ready, rsp_valid, busy, tck, tms, tdi}, 6'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_first_edge", cmd_ready, 1'b1);

    // Directed commands.
    run_cmd("tap_reset", 2'd0, 6'd0, 32'h0, 0, 1'b0);
    run_cmd("ir_l4_loop", 2'd1, 6'd4, 32'hA, 2, 1'b0);
    run_cmd("dr_l32_one", 2'd2, 6'd32, 32'h1234_5678, 1, 1'b0);
    run_cmd("dr_len0_one", 2'd2, 6'd0, 32'h0, 1, 1'b0);
    run_cmd("dr_len40_zero", 2'd2, 6'd40, 32'hFFFF_FFFF, 0, 1'b0);
    run_cmd("idle_l5_poke", 2'd3, 6'd5, 32'h0, 0, 1'b1);

    // Randomised commands against the reference model.
    for (int n = 0; n < 14; n++) begin
      run_cmd($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
              $urandom, int'($urandom_range(0, 2)), (n % 3) == 0);
    end

    // Reset asserted during bit 3 (first shift bit) of an 8-bit DR scan.
    wait_ready("mid_rst");
    tdo_mode  = 2;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_len   = 6'd8;
    cmd_data  = 32'h0000_00FF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid_rst_tck_high_before", tck, 1'b1);
    check("mid_rst_tdi_high_before", tdi, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pins_async", {tck, tms, tdi}, 3'b000);
    check("mid_rst_status_async", {busy, cmd_ready, rsp_valid}, 3'b000);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    exp_rsp = '0;
    rv_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rv_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready_low_after_release", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    check("mid_rst_ready_one_cycle_later", cmd_ready, 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rv_cnt++;
    end
    check("mid_rst_no_rsp_valid", rv_cnt, 0);

    // Recovery after reset.
    run_cmd("post_rst_tap_reset", 2'd0, 6'd3, 32'h0, 0, 1'b0);
    run_cmd("post_rst_dr_loop", 2'd2, 6'd13, 32'hDEAD_BEEF, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
